// File: rtl/router_window_addr_gen_if.sv
// router_window_addr_gen_if: coordinate-push and window-address stream bundle
// Signals: ag_en/row_id/x/y strobe a coordinate; coord_full/overflow report FIFO status;
//          addr_valid/addr_ready handshake carries addr, addr_row_id, addr_last, addr_pad;
//          addr_empty tells the controller no work is pending.
// Modports: master = controller/consumer side, slave = address generator side.
interface router_window_addr_gen_if #(
    parameter int ROW_COUNT  = 4,
    parameter int ADDR_WIDTH = 8
);
    logic                  ag_en;
    logic [ROW_COUNT-1:0]  row_id;
    logic [ADDR_WIDTH-1:0] x;
    logic [ADDR_WIDTH-1:0] y;
    logic                  coord_full;
    logic                  overflow;
    logic                  addr_valid;
    logic                  addr_ready;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ROW_COUNT-1:0]  addr_row_id;
    logic                  addr_last;
    logic                  addr_pad;
    logic                  addr_empty;
    modport master (
        output ag_en, row_id, x, y, addr_ready,
        input  coord_full, overflow, addr_valid, addr, addr_row_id, addr_last, addr_pad, addr_empty
    );
    modport slave (
        input  ag_en, row_id, x, y, addr_ready,
        output coord_full, overflow, addr_valid, addr, addr_row_id, addr_last, addr_pad, addr_empty
    );
endinterface

// File: rtl/router_window_addr_gen.sv
// router_window_addr_gen: buffers output coordinates and expands each into its KxK input-window addresses
// Optional macro ROUTER_AG_BOUNDS_EN: flag beats outside the feature map (o_addr_pad) and force their address to 0.
// Ports: i_clk clock; i_rst sync active-high reset; i_reg_clear sync clear (same effect as reset);
//        i_start_addr tile base; i_i_size row pitch / map size; i_k_size kernel size (0 treated as 1);
//        if_bus (slave) coordinate strobe in, registered address stream out, FIFO and empty status out.
module router_window_addr_gen #(
    parameter int ROW_COUNT  = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_reg_clear,
    input  logic [ADDR_WIDTH-1:0] i_start_addr,
    input  logic [ADDR_WIDTH-1:0] i_i_size,
    input  logic [ADDR_WIDTH-1:0] i_k_size,
    router_window_addr_gen_if.slave if_bus
);
    localparam int AW = ADDR_WIDTH;
    localparam int DW = 2 * ADDR_WIDTH;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = ROW_COUNT + 2 * ADDR_WIDTH;
    typedef enum logic [1:0] {IDLE, LOAD, EXPAND} state_t;
    state_t               r_state;
    logic [EW-1:0]        r_mem [FIFO_DEPTH];
    logic [PW-1:0]        r_wr_ptr;
    logic [PW-1:0]        r_rd_ptr;
    logic [CW-1:0]        r_count;
    logic                 r_overflow;
    logic [AW-1:0]        r_x;
    logic [AW-1:0]        r_y;
    logic [AW-1:0]        r_k;
    logic [AW-1:0]        r_kx;
    logic [AW-1:0]        r_ky;
    logic [ROW_COUNT-1:0] r_row_id;
    logic                 r_valid;
    logic                 r_last;
    logic                 r_pad;
    logic [AW-1:0]        r_addr;
    logic                 w_clr;
    logic                 w_full;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_fire;
    logic [EW-1:0]        w_head;
    logic [ROW_COUNT-1:0] w_head_row;
    logic [AW-1:0]        w_head_x;
    logic [AW-1:0]        w_head_y;
    logic [AW-1:0]        w_k_eff;
    logic                 w_row_end;
    logic [AW-1:0]        w_nkx;
    logic [AW-1:0]        w_nky;
    logic                 w_load;
    logic [AW-1:0]        w_cx;
    logic [AW-1:0]        w_cy;
    logic [AW-1:0]        w_ckx;
    logic [AW-1:0]        w_cky;
    logic [AW-1:0]        w_ck;
    logic [AW:0]          w_col;
    logic [AW:0]          w_row;
    logic [DW-1:0]        w_full_addr;
    logic                 w_last_n;
    logic                 w_pad_n;
    logic [AW-1:0]        w_addr_n;

    assign w_clr      = i_rst | i_reg_clear;
    assign w_full     = r_count == CW'(FIFO_DEPTH);
    // Fullness is judged on the registered count only, so a same-cycle pop never makes room.
    assign w_push     = if_bus.ag_en && !w_full;
    assign w_pop      = r_state == LOAD;
    assign w_fire     = r_valid && if_bus.addr_ready;
    assign w_head     = r_mem[r_rd_ptr];
    assign w_head_row = w_head[EW-1 -: ROW_COUNT];
    assign w_head_x   = w_head[2*AW-1 -: AW];
    assign w_head_y   = w_head[AW-1:0];
    assign w_k_eff    = (i_k_size == '0) ? AW'(1) : i_k_size;
    assign w_row_end  = r_kx == r_k - AW'(1);
    assign w_nkx      = w_row_end ? '0 : r_kx + AW'(1);
    assign w_nky      = w_row_end ? r_ky + AW'(1) : r_ky;

    // One address datapath serves both the first beat (from the FIFO head in LOAD)
    // and every following beat (from the latched coordinate and the next kx/ky).
    assign w_load      = r_state == LOAD;
    assign w_cx        = w_load ? w_head_x : r_x;
    assign w_cy        = w_load ? w_head_y : r_y;
    assign w_ckx       = w_load ? '0 : w_nkx;
    assign w_cky       = w_load ? '0 : w_nky;
    assign w_ck        = w_load ? w_k_eff : r_k;
    assign w_col       = {1'b0, w_cx} + {1'b0, w_ckx};
    assign w_row       = {1'b0, w_cy} + {1'b0, w_cky};
    assign w_full_addr = DW'(i_start_addr) + DW'(w_row) * DW'(i_i_size) + DW'(w_col);
    assign w_last_n    = (w_ckx == w_ck - AW'(1)) && (w_cky == w_ck - AW'(1));
`ifdef ROUTER_AG_BOUNDS_EN
    assign w_pad_n     = (w_col >= {1'b0, i_i_size}) || (w_row >= {1'b0, i_i_size});
`else
    assign w_pad_n     = 1'b0;
`endif
    assign w_addr_n    = w_pad_n ? '0 : w_full_addr[AW-1:0];

    always_ff @(posedge i_clk) begin
        if (w_push && !w_clr) r_mem[r_wr_ptr] <= {if_bus.row_id, if_bus.x, if_bus.y};
    end

    always_ff @(posedge i_clk) begin
        if (w_clr) begin
            r_state    <= IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_x        <= '0;
            r_y        <= '0;
            r_k        <= '0;
            r_kx       <= '0;
            r_ky       <= '0;
            r_row_id   <= '0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_pad      <= 1'b0;
            r_addr     <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            if (if_bus.ag_en && w_full) r_overflow <= 1'b1;
            case (r_state)
                IDLE: if (r_count != '0) r_state <= LOAD;
                LOAD: begin
                    r_x      <= w_head_x;
                    r_y      <= w_head_y;
                    r_row_id <= w_head_row;
                    r_k      <= w_k_eff;
                    r_kx     <= '0;
                    r_ky     <= '0;
                    r_valid  <= 1'b1;
                    r_addr   <= w_addr_n;
                    r_last   <= w_last_n;
                    r_pad    <= w_pad_n;
                    r_state  <= EXPAND;
                end
                EXPAND: if (w_fire) begin
                    if (r_last) begin
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        r_pad   <= 1'b0;
                        r_addr  <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_kx   <= w_nkx;
                        r_ky   <= w_nky;
                        r_addr <= w_addr_n;
                        r_last <= w_last_n;
                        r_pad  <= w_pad_n;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign if_bus.coord_full  = w_full;
    assign if_bus.overflow    = r_overflow;
    assign if_bus.addr_valid  = r_valid;
    assign if_bus.addr        = r_addr;
    assign if_bus.addr_row_id = r_row_id;
    assign if_bus.addr_last   = r_last;
    assign if_bus.addr_pad    = r_pad;
    assign if_bus.addr_empty  = (r_count == '0) && (r_state == IDLE);
endmodule

// File: tb/tb_router_window_addr_gen.sv
// tb_router_window_addr_gen: directed scenarios plus randomized traffic against a queue-based window model
module tb_router_window_addr_gen;
    localparam int RC    = 4;
    localparam int AW    = 8;
    localparam int DEPTH = 4;
    localparam int MASK  = (1 << AW) - 1;
    typedef struct {int x; int y; int r;} coord_t;
    typedef struct {int addr; int last; int pad; int row;} beat_t;
    logic clk, rst, clr;
    logic [AW-1:0] start, isize, ksize;
    router_window_addr_gen_if #(.ROW_COUNT(RC), .ADDR_WIDTH(AW)) bus ();
    router_window_addr_gen #(.ROW_COUNT(RC), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst(rst), .i_reg_clear(clr), .i_start_addr(start),
        .i_i_size(isize), .i_k_size(ksize), .if_bus(bus)
    );
    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int mode = 0;
    coord_t m_fifo[$];
    beat_t m_beats[$];
    int m_phase = 0;
    bit m_ovf = 0;
    bit m_on = 0;
    bit m_push;
    coord_t m_c;
    int got_addr[$];
    int got_last[$];
    int got_pad[$];

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Window model: each accepted coordinate becomes K*K beats in row-major order.
    function automatic void expand(coord_t c);
        int k, col, row, a, p;
        k = (ksize == 0) ? 1 : int'(ksize);
        for (int ky = 0; ky < k; ky++)
            for (int kx = 0; kx < k; kx++) begin
                col = c.x + kx;
                row = c.y + ky;
                a = (int'(start) + row * int'(isize) + col) & MASK;
                p = 0;
`ifdef ROUTER_AG_BOUNDS_EN
                p = (col >= int'(isize) || row >= int'(isize)) ? 1 : 0;
                if (p == 1) a = 0;
`endif
                m_beats.push_back('{a, (kx == k - 1 && ky == k - 1) ? 1 : 0, p, c.r});
            end
    endfunction

    // Block phases: 0 idle, 1 loading a coordinate, 2 presenting beats.
    always @(posedge clk) begin
        if (rst || clr) begin
            m_fifo.delete();
            m_beats.delete();
            m_phase = 0;
            m_ovf = 0;
            m_on = 1;
        end else if (m_on) begin
            m_push = bus.ag_en && m_fifo.size() < DEPTH;
            if (bus.ag_en && !m_push) m_ovf = 1;
            m_c = '{int'(bus.x), int'(bus.y), int'(bus.row_id)};
            case (m_phase)
                0: if (m_fifo.size() > 0) m_phase = 1;
                1: begin
                    expand(m_fifo.pop_front());
                    m_phase = 2;
                end
                default: if (bus.addr_ready) begin
                    void'(m_beats.pop_front());
                    if (m_beats.size() == 0) m_phase = 0;
                end
            endcase
            if (m_push) m_fifo.push_back(m_c);
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            chk("addr_valid", int'(bus.addr_valid), (m_phase == 2) ? 1 : 0);
            chk("addr_empty", int'(bus.addr_empty), (m_fifo.size() == 0 && m_phase == 0) ? 1 : 0);
            chk("coord_full", int'(bus.coord_full), (m_fifo.size() == DEPTH) ? 1 : 0);
            chk("overflow", int'(bus.overflow), int'(m_ovf));
            if (m_phase == 2 && m_beats.size() > 0) begin
                chk("addr", int'(bus.addr), m_beats[0].addr);
                chk("addr_last", int'(bus.addr_last), m_beats[0].last);
                chk("addr_pad", int'(bus.addr_pad), m_beats[0].pad);
                chk("addr_row_id", int'(bus.addr_row_id), m_beats[0].row);
            end
            if (bus.addr_valid && bus.addr_ready && !rst && !clr) begin
                got_addr.push_back(int'(bus.addr));
                got_last.push_back(int'(bus.addr_last));
                got_pad.push_back(int'(bus.addr_pad));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
        cyc++;
        case (mode)
            0: bus.addr_ready = 1'b1;
            1: bus.addr_ready = (cyc % 3 == 0);
            2: bus.addr_ready = 1'($urandom_range(0, 1));
            default: bus.addr_ready = 1'b0;
        endcase
    endtask

    task automatic strobe(input int x, input int y, input int r);
        bus.ag_en = 1'b1;
        bus.x = AW'(x);
        bus.y = AW'(y);
        bus.row_id = RC'(r);
        step();
        bus.ag_en = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (!bus.addr_empty && n < budget) begin
            step();
            n++;
        end
        chk("drain_idle", int'(bus.addr_empty), 1);
    endtask

    task automatic cfg(input int s, input int i, input int k);
        start = AW'(s);
        isize = AW'(i);
        ksize = AW'(k);
    endtask

    task automatic clear_got();
        got_addr.delete();
        got_last.delete();
        got_pad.delete();
    endtask

    initial begin
        int e1[9] = '{'h1B, 'h1C, 'h1D, 'h20, 'h21, 'h22, 'h25, 'h26, 'h27};
`ifdef ROUTER_AG_BOUNDS_EN
        int e6a[9] = '{'h0A, 'h0B, 0, 'h0E, 'h0F, 0, 0, 0, 0};
        int e6p[9] = '{0, 0, 1, 0, 0, 1, 1, 1, 1};
`else
        int e6a[9] = '{'h0A, 'h0B, 'h0C, 'h0E, 'h0F, 'h10, 'h12, 'h13, 'h14};
        int e6p[9] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
`endif
        int n;
        rst = 1; clr = 0;
        bus.ag_en = 0; bus.x = 0; bus.y = 0; bus.row_id = 0; bus.addr_ready = 0;
        cfg('h10, 5, 3);
        repeat (3) step();
        rst = 0;
        chk("rst_valid", int'(bus.addr_valid), 0);
        chk("rst_empty", int'(bus.addr_empty), 1);
        chk("rst_full", int'(bus.coord_full), 0);
        chk("rst_overflow", int'(bus.overflow), 0);
        chk("rst_addr", int'(bus.addr), 0);
        chk("rst_last", int'(bus.addr_last), 0);
        chk("rst_pad", int'(bus.addr_pad), 0);
        chk("rst_row_id", int'(bus.addr_row_id), 0);

        // Single window with latency measurement.
        mode = 0;
        step();
        clear_got();
        bus.ag_en = 1; bus.x = 1; bus.y = 2; bus.row_id = 2;
        step();
        bus.ag_en = 0;
        n = 1;
        while (!bus.addr_valid && n < 10) begin
            step();
            n++;
        end
        chk("latency", n, 3);
        drain(100);
        chk("s1_beats", got_addr.size(), 9);
        for (int i = 0; i < 9; i++) begin
            chk("s1_addr", got_addr[i], e1[i]);
            chk("s1_last", got_last[i], (i == 8) ? 1 : 0);
        end

        // Backpressure 1,0,0 pattern.
        mode = 1;
        clear_got();
        strobe(1, 2, 2);
        drain(200);
        chk("s2_beats", got_addr.size(), 9);
        for (int i = 0; i < 9; i++) chk("s2_addr", got_addr[i], e1[i]);

        // Full FIFO and sticky overflow.
        mode = 3;
        cfg(0, 8, 1);
        step();
        clear_got();
        for (int i = 0; i < 5; i++) strobe(i, 0, 1);
        chk("s3_full", int'(bus.coord_full), 1);
        chk("s3_no_overflow", int'(bus.overflow), 0);
        strobe(5, 0, 1);
        chk("s3_overflow", int'(bus.overflow), 1);
        repeat (4) step();
        chk("s3_overflow_sticky", int'(bus.overflow), 1);
        mode = 0;
        drain(100);
        chk("s3_beats", got_addr.size(), 5);
        chk("s3_last_addr", got_addr[4], 4);
        chk("s3_overflow_held", int'(bus.overflow), 1);

        // Clear mid-window with two coordinates queued.
        cfg('h10, 5, 3);
        clear_got();
        strobe(1, 2, 2);
        strobe(0, 0, 1);
        strobe(3, 3, 3);
        n = 0;
        while (!(got_addr.size() == 3 && bus.addr_valid) && n < 50) begin
            step();
            n++;
        end
        chk("s5_reached_beat4", int'(bus.addr), 'h20);
        clr = 1;
        step();
        clr = 0;
        chk("s5_valid", int'(bus.addr_valid), 0);
        chk("s5_empty", int'(bus.addr_empty), 1);
        chk("s5_overflow", int'(bus.overflow), 0);
        repeat (10) step();
        chk("s5_no_more_beats", got_addr.size(), 3);

        // K = 0 and K = 1 both give a single beat.
        for (int k = 0; k < 2; k++) begin
            cfg(0, 8, k);
            clear_got();
            strobe(3, 0, 1);
            drain(50);
            chk("s4_beats", got_addr.size(), 1);
            chk("s4_addr", got_addr[0], 3);
            chk("s4_last", got_last[0], 1);
        end

        // Window crossing the feature-map edge.
        cfg(0, 4, 3);
        clear_got();
        strobe(2, 2, 0);
        drain(50);
        chk("s6_beats", got_addr.size(), 9);
        for (int i = 0; i < 9; i++) begin
            chk("s6_addr", got_addr[i], e6a[i]);
            chk("s6_pad", got_pad[i], e6p[i]);
        end

        // Randomized traffic, config changed only while idle.
        for (int r = 0; r < 8; r++) begin
            cfg($urandom_range(0, 255), $urandom_range(1, 12), $urandom_range(0, 3));
            mode = 2;
            for (int c = 0; c < 150; c++) begin
                bus.ag_en = ($urandom_range(0, 2) == 0);
                bus.x = AW'($urandom_range(0, 15));
                bus.y = AW'($urandom_range(0, 15));
                bus.row_id = RC'($urandom);
                clr = (r == 5 && c == 60);
                step();
            end
            bus.ag_en = 0;
            clr = 0;
            drain(3000);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
